alu_issue_driver: RTL and testbench

//  Initiator-side driver for the ALU interface: owns Port_A/Port_B/ALUOP, consumes Zero/Negative/Overflow/Output_Port.

---
 rtl/cpu_types_pkg.sv | 46 ++++
 rtl/alu_req_fifo.sv | 71 +++++++
 rtl/alu_issue_driver.sv | 160 ++++++++++++++++
 tb/tb_alu_issue_driver.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the ALU issue driver: operand word, ALU
// operation code, request/flag bundles, driver FSM state and a saturating
// statistics increment helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        word_t  a;
        word_t  b;
        aluop_t op;
    } alu_req_t;

    typedef struct packed {
        logic ovf;
        logic neg;
        logic zero;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } alu_drv_state_t;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    // Saturating +1 for the optional 16-bit statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == STAT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO for the ALU issue driver. Holds DEPTH entries of
// {alu_req_t, tag}. push_ready is derived from a registered full flag so
// there is no combinational path from push_valid or pop to push_ready; it
// is forced low while reset is asserted.
module alu_req_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  alu_req_t         push_req,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output alu_req_t         head_req,
    output logic [TAG_W-1:0] head_tag,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    alu_req_t         req_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign push_ready = rst_n & ~full_q;
    assign empty      = (count == '0);
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop & ~empty;
    assign head_req   = req_mem[rd_ptr];
    assign head_tag   = tag_mem[rd_ptr];

    // Occupancy after this cycle's push/pop; feeds the registered full flag.
    always_comb begin
        count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointers wrap naturally mod DEPTH; count carries one extra bit for full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_next;
            full_q <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            req_mem[wr_ptr] <= push_req;
            tag_mem[wr_ptr] <= push_tag;
        end
    end

endmodule

// File: rtl/alu_issue_driver.sv
// Initiator-side driver for the combinational ALU. Requests are buffered in
// alu_req_fifo, issued one per cycle into registered alu_a/alu_b/alu_op, and
// the ALU result plus {ovf,neg,zero} are captured with the request tag into a
// response register.
//
// Handshakes (both req_* and rsp_*): a transfer happens on a rising CLK edge
// where valid && ready are both high. The source holds payload stable while
// valid && !ready; ready never depends combinationally on valid.
//
// Optional build macro ALU_ISSUE_STATS_EN adds saturating counters
// stat_issued (captures) and stat_ovf (captures with alu_ovf=1).
module alu_issue_driver
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             req_valid,
    output logic             req_ready,
    input  word_t            req_a,
    input  word_t            req_b,
    input  aluop_t           req_op,
    input  logic [TAG_W-1:0] req_tag,
    output word_t            alu_a,
    output word_t            alu_b,
    output aluop_t           alu_op,
    input  word_t            alu_out,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output word_t            rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output alu_drv_state_t   dbg_state
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]      stat_issued,
    output logic [15:0]      stat_ovf
`endif
);

    alu_drv_state_t   state;
    alu_drv_state_t   state_next;
    alu_req_t         push_req;
    alu_req_t         head_req;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] issue_tag;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             capture;
    logic             rsp_free;
    alu_flags_t       cur_flags;

    assign push_req  = '{a: req_a, b: req_b, op: req_op};
    assign cur_flags = '{ovf: alu_ovf, neg: alu_neg, zero: alu_zero};
    // Response register can take a new capture if empty or being drained now.
    assign rsp_free  = ~rsp_valid | rsp_ready;
    assign dbg_state = state;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (nRST),
        .push_valid (req_valid),
        .push_ready (req_ready),
        .push_req   (push_req),
        .push_tag   (req_tag),
        .pop        (fifo_pop),
        .head_req   (head_req),
        .head_tag   (head_tag),
        .empty      (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, FIFO pop and response capture decisions.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE, HOLD: begin
                if (rsp_free) begin
                    capture = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = DRIVE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ALU operand registers: load on pop, otherwise hold the last issued op.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= aluop_t'(0);
            issue_tag <= '0;
        end else if (fifo_pop) begin
            alu_a     <= head_req.a;
            alu_b     <= head_req.b;
            alu_op    <= head_req.op;
            issue_tag <= head_tag;
        end
    end

    // Response register: capture sets valid, accept without capture clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_tag    <= '0;
        end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_out;
            rsp_flags  <= cur_flags;
            rsp_tag    <= issue_tag;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Saturating issue / overflow counters, stepped once per capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_issued <= '0;
            stat_ovf    <= '0;
        end else if (capture) begin
            stat_issued <= sat_inc(stat_issued);
            if (alu_ovf) stat_ovf <= sat_inc(stat_ovf);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_driver.sv
// Self-checking bench for alu_issue_driver: behavioural ALU on the alu_*
// side, request driver task, expected-response queue filled at request
// accept and drained by an independent response monitor.
module tb_alu_issue_driver;
    import cpu_types_pkg::*;

    localparam int DEPTH        = 4;
    localparam int TAG_W        = 4;
    localparam int EW           = TAG_W + 3 + 32;
    localparam int ACCEPT_LIMIT = 200;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    word_t            req_a = '0;
    word_t            req_b = '0;
    aluop_t           req_op = ALU_ADD;
    logic [TAG_W-1:0] req_tag = '0;
    word_t            alu_a;
    word_t            alu_b;
    aluop_t           alu_op;
    word_t            alu_out;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_ovf;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    word_t            rsp_result;
    logic [2:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    alu_drv_state_t   dbg_state;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]      stat_issued;
    logic [15:0]      stat_ovf;
`endif

    int               checks = 0;
    int               errors = 0;
    int               cycle = 0;
    logic [EW-1:0]    exp_q[$];
    int               rsp_cycle[$];
    logic [EW-1:0]    last_rsp = '0;
    int               exp_issued = 0;
    int               exp_ovf = 0;
    logic             rand_done = 1'b0;

    // clock / reset block
    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    alu_issue_driver #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_tag    (req_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_tag    (rsp_tag),
        .dbg_state  (dbg_state)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_ovf    (stat_ovf)
`endif
    );

    // Behavioural ALU: returns {ovf, neg, zero, result} from plain arithmetic.
    function automatic logic [34:0] alu_ref(input word_t a, input word_t b, input aluop_t op);
        longint sa;
        longint sb;
        longint s;
        word_t  r;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = 0;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin s = sa + sb; r = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            ALU_SUB: begin s = sa - sb; r = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOR: r = ~(a | b);
            ALU_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {ovf, r[31], (r == 32'd0), r};
    endfunction

    assign {alu_ovf, alu_neg, alu_zero, alu_out} = alu_ref(alu_a, alu_b, alu_op);

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
        end
    endfunction

    // driver task: present one request, wait for accept, record expectation
    task automatic send(input word_t a, input word_t b, input aluop_t op, input logic [TAG_W-1:0] tag);
        logic        rdy;
        int          waited;
        logic [34:0] r;
        rdy    = 1'b0;
        waited = 0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_tag   = tag;
        while (!rdy && waited < ACCEPT_LIMIT) begin
            rdy = req_ready;
            @(posedge CLK);
            if (!rdy) begin
                #1;
                waited++;
            end
        end
        if (rdy) begin
            r = alu_ref(a, b, op);
            exp_q.push_back({tag, r[34:32], r[31:0]});
            if (exp_issued < 65535) exp_issued++;
            if (r[34] && exp_ovf < 65535) exp_ovf++;
        end else begin
            check("req_accept_timeout", 64'd0, 64'd1);
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #2;
        exp_q.delete();
        exp_issued = 0;
        exp_ovf    = 0;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'({rsp_tag, rsp_flags, rsp_result}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
`ifdef ALU_ISSUE_STATS_EN
        check("rst_stats", 64'({stat_issued, stat_ovf}), 64'd0);
`endif
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        // FIFO must have come out of reset empty: nothing issued, ready high
        check("post_rst_ready", 64'(req_ready), 64'd1);
        check("post_rst_state", 64'(dbg_state), 64'(IDLE));
        check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    endtask

    // scoreboard monitor: pops expectations on every response handshake
    logic          prev_hold = 1'b0;
    logic [EW-1:0] prev_data = '0;
    always @(negedge CLK) begin
        logic [EW-1:0] e;
        if (!nRST) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                check("rsp_hold_stable", 64'({rsp_tag, rsp_flags, rsp_result}), 64'(prev_data));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_tag", 64'(rsp_tag), 64'(e[EW-1 -: TAG_W]));
                    check("rsp_result", 64'(rsp_result), 64'(e[31:0]));
                    check("rsp_flags", 64'(rsp_flags), 64'(e[34:32]));
                end
                rsp_cycle.push_back(cycle);
                last_rsp = {rsp_tag, rsp_flags, rsp_result};
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = {rsp_tag, rsp_flags, rsp_result};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // ---- reset state
        do_reset();

        // ---- latency: SUB 5-5
        rsp_ready = 1'b1;
        send(32'd5, 32'd5, ALU_SUB, 4'd5);
        check("lat_no_rsp_n", 64'(rsp_valid), 64'd0);
        @(posedge CLK); #1;
        check("lat_alu_a", 64'(alu_a), 64'd5);
        check("lat_alu_b", 64'(alu_b), 64'd5);
        check("lat_alu_op", 64'(alu_op), 64'(ALU_SUB));
        check("lat_no_rsp_n1", 64'(rsp_valid), 64'd0);
        @(posedge CLK); #1;
        check("lat_rsp_valid_n2", 64'(rsp_valid), 64'd1);
        check("lat_rsp", 64'({rsp_tag, rsp_flags, rsp_result}), 64'({4'd5, 3'b001, 32'd0}));
        drain();
        check("idle_alu_hold", 64'(alu_a), 64'd5);

        // ---- streaming: 8 back-to-back ADDs
        base = rsp_cycle.size();
        for (int i = 0; i < 8; i++) send(word_t'(i), word_t'(i), ALU_ADD, TAG_W'(i));
        drain();
        check("stream_count", 64'(rsp_cycle.size() - base), 64'd8);
        if (rsp_cycle.size() >= base + 8)
            check("stream_consecutive", 64'(rsp_cycle[base + 7] - rsp_cycle[base]), 64'd7);
        check("stream_last", 64'(last_rsp), 64'({4'd7, 3'b000, 32'd14}));

        // ---- backpressure: DEPTH+3 pushes with rsp_ready low
        rsp_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < DEPTH + 3; i++)
                    send($urandom, $urandom, ALU_XOR, TAG_W'(i + 8));
            end
            begin
                repeat (30) @(posedge CLK);
                #1;
                check("bp_ready_low", 64'(req_ready), 64'd0);
                check("bp_accepted", 64'(exp_q.size()), 64'(DEPTH + 2));
                check("bp_state_hold", 64'(dbg_state), 64'(HOLD));
                rsp_ready = 1'b1;
            end
        join
        drain();

        // ---- randomized traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    word_t a;
                    word_t b;
                    a = ($urandom_range(0, 3) == 0) ? word_t'($urandom_range(0, 8)) : word_t'($urandom);
                    b = ($urandom_range(0, 3) == 0) ? a : word_t'($urandom);
                    send(a, b, aluop_t'($urandom_range(0, 9)), TAG_W'($urandom));
                    repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge CLK);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        drain();
`ifdef ALU_ISSUE_STATS_EN
        check("stat_issued_model", 64'(stat_issued), 64'(exp_issued));
        check("stat_ovf_model", 64'(stat_ovf), 64'(exp_ovf));
`endif

        // ---- reset mid-burst, then ADD 1+2 tag 3
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(word_t'(i + 100), 32'd1, ALU_ADD, TAG_W'(i));
        @(posedge CLK); #1;
        do_reset();
        rsp_ready = 1'b1;
        send(32'd1, 32'd2, ALU_ADD, 4'd3);
        drain();
        check("post_rst_first", 64'(last_rsp), 64'({4'd3, 3'b000, 32'd3}));

        // ---- flags: signed overflow on ADD
        do_reset();
        send(32'h7FFF_FFFF, 32'd1, ALU_ADD, 4'd9);
        drain();
        check("ovf_result", 64'(last_rsp[31:0]), 64'h8000_0000);
        check("ovf_flags", 64'(last_rsp[34:32]), 64'(3'b110));
`ifdef ALU_ISSUE_STATS_EN
        check("ovf_stat_ovf", 64'(stat_ovf), 64'd1);
        check("ovf_stat_issued", 64'(stat_issued), 64'd1);

        // ---- saturation of the issue counter
        do_reset();
        for (int i = 0; i < 65540; i++) send(word_t'(i), 32'd1, ALU_ADD, TAG_W'(i));
        drain();
        check("sat_issued", 64'(stat_issued), 64'hFFFF);
        check("sat_ovf", 64'(stat_ovf), 64'(exp_ovf));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
